// File: rtl/uart_tx_io_if.sv
// Bus port bundle for the uart_tx_io peripheral: qualified IO access, write
// mask/data, read strobe and the registered read data returned to the SoC.
interface uart_tx_io_if;
    logic        sel;
    logic [1:0]  addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        rstrb;
    logic [31:0] rdata;

    modport master (
        output sel,
        output addr,
        output wmask,
        output wdata,
        output rstrb,
        input  rdata
    );

    modport slave (
        input  sel,
        input  addr,
        input  wmask,
        input  wdata,
        input  rstrb,
        output rdata
    );
endinterface

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by DATA writes, status and
// control registers, serialiser FSM and a TX-empty interrupt.
module uart_tx_io #(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_io_if.slave  bus,
    output logic         tx,
    output logic         irq
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [7:0]      shift_r;
    logic [2:0]      bit_idx_r;
    logic [BW-1:0]   baud_cnt_r;
    logic            tx_r;

    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            overflow_r;
    logic            irq_en_r;
    logic [31:0]     rdata_r;

    logic            full_s;
    logic            empty_s;
    logic            busy_s;
    logic            baud_done_s;
    logic            wr_s;
    logic            push_req_s;
    logic            push_s;
    logic            pop_s;
    logic            status_rd_s;
    logic            ctrl_wr_s;
    logic [31:0]     rd_data_s;
    logic            unused_bits_s;

    function automatic logic [31:0] status_word(
        input logic          full,
        input logic          empty,
        input logic          busy,
        input logic          ovf,
        input logic [CW-1:0] cnt
    );
        logic [31:0] w;
        w       = 32'h0000_0000;
        w[0]    = full;
        w[1]    = empty;
        w[2]    = busy;
        w[3]    = ovf;
        w[12:8] = 5'(cnt);
        return w;
    endfunction

    assign full_s      = (count_r == DEPTH_C);
    assign empty_s     = (count_r == {CW{1'b0}});
    assign busy_s      = (state_r != ST_IDLE);
    assign baud_done_s = (baud_cnt_r == BAUD_LAST);

    assign wr_s        = bus.sel & bus.wmask[0];
    assign push_req_s  = wr_s & (bus.addr == 2'd0);
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost.
    assign push_s      = push_req_s & ~full_s;
    assign ctrl_wr_s   = wr_s & (bus.addr == 2'd2);
    assign status_rd_s = bus.sel & bus.rstrb & (bus.addr == 2'd1);

    // The serialiser takes a byte when idle, or straight out of a finished stop bit.
    assign pop_s = ~empty_s & ((state_r == ST_IDLE) | ((state_r == ST_STOP) & baud_done_s));

    assign unused_bits_s = ^{bus.wdata[31:8], bus.wmask[3:1]};

    // Read mux: selects the register image loaded into rdata on a read strobe.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (bus.addr)
            2'd1:    rd_data_s = status_word(full_s, empty_s, busy_s, overflow_r, count_r);
            2'd2:    rd_data_s = {31'h0000_0000, irq_en_r};
            default: rd_data_s = 32'h0000_0000;
        endcase
    end

    // FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.wdata[7:0];
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow, interrupt enable and registered read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
            irq_en_r   <= 1'b0;
            rdata_r    <= 32'h0000_0000;
        end else begin
            if (push_req_s && full_s) begin
                overflow_r <= 1'b1;
            end else if (status_rd_s) begin
                overflow_r <= 1'b0;
            end
            if (ctrl_wr_s) begin
                irq_en_r <= bus.wdata[0];
            end
            if (bus.sel && bus.rstrb) begin
                rdata_r <= rd_data_s;
            end
        end
    end

    // Serialiser FSM: start bit, eight data bits LSB first, stop bit; tx is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            shift_r    <= 8'h00;
            bit_idx_r  <= 3'd0;
            baud_cnt_r <= {BW{1'b0}};
            tx_r       <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= {BW{1'b0}};
                    if (pop_s) begin
                        shift_r <= mem_r[rd_ptr_r];
                        state_r <= ST_START;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        bit_idx_r  <= 3'd0;
                        state_r    <= ST_DATA;
                        tx_r       <= shift_r[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            shift_r   <= {1'b0, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        if (pop_s) begin
                            shift_r <= mem_r[rd_ptr_r];
                            state_r <= ST_START;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= {BW{1'b0}};
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_r;
    assign tx        = tx_r;
    assign irq       = irq_en_r & empty_s & ~busy_s;

endmodule

// File: tb/tb_uart_tx_io.sv
// Self-checking bench for uart_tx_io: a line monitor decodes 8N1 frames from tx
// and each scenario compares them against bytes predicted from the register rules.
module tb_uart_tx_io;
    localparam int CLK_HZ = 48000000;
    localparam int BAUD   = 115200;
    localparam int DEPTH  = 8;
    localparam int DIV    = CLK_HZ / BAUD;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic irq;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [9:0] rx_q[$];
    int         rx_start_q[$];

    uart_tx_io_if bus();

    uart_tx_io #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .irq   (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: frame word is {stop, data[7:0], start}, sampled mid-bit.
    initial begin
        bit         m_act;
        logic       m_prev;
        int         m_cnt;
        int         m_start;
        logic [9:0] m_frame;
        m_act = 1'b0; m_prev = 1'b1; m_cnt = 0; m_start = 0; m_frame = 10'h000;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                m_act = 1'b0;
            end else if (!m_act) begin
                if (tx === 1'b0 && m_prev === 1'b1) begin
                    m_act = 1'b1; m_cnt = 0; m_start = cyc; m_frame = 10'h000;
                end
            end else begin
                m_cnt++;
                if (m_cnt % DIV == DIV / 2) begin
                    m_frame[m_cnt / DIV] = tx;
                    if (m_cnt / DIV == 9) begin
                        rx_q.push_back(m_frame);
                        rx_start_q.push_back(m_start);
                        m_act = 1'b0;
                    end
                end
            end
            m_prev = tx;
        end
    end

    // All bus tasks are entered at a negedge and return at the following negedge.
    task automatic do_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.sel = 1'b1; bus.addr = a; bus.wmask = m; bus.wdata = d; bus.rstrb = 1'b0;
        @(negedge clk);
        bus.sel = 1'b0; bus.wmask = 4'b0000;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        bus.sel = 1'b1; bus.addr = a; bus.wmask = 4'b0000; bus.rstrb = 1'b1;
        @(negedge clk);
        bus.sel = 1'b0; bus.rstrb = 1'b0;
        d = bus.rdata;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (rx_q.size() >= n) break;
            @(negedge clk);
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_start_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b want=1", tx); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", irq); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.rdata); end
        reset = 1'b1;
        repeat (1000) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL idle_tx got=%b want=1", tx); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL idle_irq got=%b want=0", irq); end
        do_read(2'd1, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL idle_status got=%h want=00000002", d); end
        total++; if (rx_q.size() !== 0) begin bad++; $display("FAIL idle_frames got=%0d want=0", rx_q.size()); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        do_write(2'd2, 32'($urandom) | 32'h1, 4'b0001);
        do_read(2'd2, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL ctrl_set got=%h want=00000001", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL ctrl_irq_on got=%b want=1", irq); end
        do_write(2'd2, 32'($urandom) & 32'hFFFF_FFFE, 4'b0001);
        do_read(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_clr got=%h want=0", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL ctrl_irq_off got=%b want=0", irq); end
        do_write(2'd0, 32'($urandom), 4'b1110);
        do_write(2'd3, 32'($urandom), 4'b1111);
        do_read(2'd1, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL masked_write_status got=%h want=00000002", d); end
        do_read(2'd3, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reserved_read got=%h want=0", d); end
        do_read(2'd1, d);
        do_read(2'd0, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL data_read got=%h want=0", d); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        int          w_cyc;
        bit          ok;
        clear_rx();
        do_write(2'd0, 32'h55, 4'b0001);
        w_cyc = cyc;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_pre got=%b want=1", tx); end
        @(negedge clk);
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL single_start got=%b want=0", tx); end
        do_read(2'd1, d);
        total++; if (d !== 32'h6) begin bad++; $display("FAIL single_busy_status got=%h want=00000006", d); end
        wait_rx(1, 11 * DIV, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL single_timeout got=%0d frames want=1", rx_q.size());
        end else begin
            total++; if (rx_q[0] !== {1'b1, 8'h55, 1'b0}) begin bad++; $display("FAIL single_frame got=%h want=%h", rx_q[0], {1'b1, 8'h55, 1'b0}); end
            total++; if (rx_start_q[0] !== w_cyc + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", rx_start_q[0], w_cyc + 1); end
        end
        repeat (DIV) @(negedge clk);
        do_read(2'd1, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL single_end_status got=%h want=00000002", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [3];
        int         w_cyc;
        bit         ok;
        b[0] = 8'hA5; b[1] = 8'h3C; b[2] = 8'hFF;
        clear_rx();
        do_write(2'd0, {24'h0, b[0]}, 4'b0001);
        w_cyc = cyc;
        do_write(2'd0, {24'h0, b[1]}, 4'b0001);
        do_write(2'd0, {24'h0, b[2]}, 4'b0001);
        wait_rx(3, 31 * DIV, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL b2b_timeout got=%0d frames want=3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (rx_q[i] !== {1'b1, b[i], 1'b0}) begin bad++; $display("FAIL b2b_frame%0d got=%h want=%h", i, rx_q[i], {1'b1, b[i], 1'b0}); end
                total++; if (rx_start_q[i] !== w_cyc + 1 + i * 10 * DIV) begin bad++; $display("FAIL b2b_start%0d got=%0d want=%0d", i, rx_start_q[i], w_cyc + 1 + i * 10 * DIV); end
            end
        end
        repeat (DIV) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [7:0]  bytes [10];
        logic [7:0]  exp_q[$];
        int          occ, idle, ovf, pop, full;
        logic [31:0] d, e;
        bit          ok;
        clear_rx();
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
        // Occupancy model: one write per cycle, idle transmitter takes the first byte on the next edge.
        occ = 0; idle = 1; ovf = 0;
        for (int k = 0; k < 10; k++) begin
            pop  = (idle != 0 && occ > 0) ? 1 : 0;
            full = (occ == DEPTH) ? 1 : 0;
            if (full == 0) exp_q.push_back(bytes[k]); else ovf = 1;
            occ = occ + (1 - full) - pop;
            if (pop != 0) idle = 0;
        end
        for (int k = 0; k < 10; k++) do_write(2'd0, {24'h0, bytes[k]}, 4'b0001);
        e = (32'(occ) << 8) | ((ovf != 0) ? 32'h8 : 32'h0) | 32'h4 |
            ((occ == 0) ? 32'h2 : 32'h0) | ((occ == DEPTH) ? 32'h1 : 32'h0);
        do_read(2'd1, d);
        total++; if (d !== e) begin bad++; $display("FAIL ovf_status got=%h want=%h", d, e); end
        do_read(2'd1, d);
        total++; if (d !== (e & 32'hFFFF_FFF7)) begin bad++; $display("FAIL ovf_cleared got=%h want=%h", d, e & 32'hFFFF_FFF7); end
        wait_rx(exp_q.size(), (exp_q.size() + 1) * 10 * DIV, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL ovf_timeout got=%0d frames want=%0d", rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++; if (rx_q[i] !== {1'b1, exp_q[i], 1'b0}) begin bad++; $display("FAIL ovf_frame%0d got=%h want=%h", i, rx_q[i], {1'b1, exp_q[i], 1'b0}); end
            end
        end
        repeat (DIV) @(negedge clk);
        do_read(2'd1, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL ovf_end_status got=%h want=00000002", d); end
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    endtask

    task automatic test_irq();
        logic [7:0] b0, b1;
        int         w_cyc, rise;
        bit         ok;
        clear_rx();
        b0 = 8'($urandom); b1 = 8'($urandom);
        do_write(2'd2, 32'h1, 4'b0001);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_idle got=%b want=1", irq); end
        do_write(2'd0, {24'h0, b0}, 4'b0001);
        w_cyc = cyc;
        do_write(2'd0, {24'h0, b1}, 4'b0001);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_busy got=%b want=0", irq); end
        rise = -1;
        for (int k = 0; k < 25 * DIV; k++) begin
            if (irq === 1'b1) begin rise = cyc; break; end
            @(negedge clk);
        end
        total++; if (rise !== w_cyc + 1 + 20 * DIV) begin bad++; $display("FAIL irq_rise got=%0d want=%0d", rise, w_cyc + 1 + 20 * DIV); end
        wait_rx(2, 2, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL irq_frames got=%0d want=2", rx_q.size());
        end else begin
            total++; if (rx_q[0] !== {1'b1, b0, 1'b0} || rx_q[1] !== {1'b1, b1, 1'b0}) begin bad++; $display("FAIL irq_data got=%h,%h want=%h,%h", rx_q[0], rx_q[1], {1'b1, b0, 1'b0}, {1'b1, b1, 1'b0}); end
        end
        do_write(2'd2, 32'h0, 4'b0001);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_disable got=%b want=0", irq); end
    endtask

    task automatic test_reset_midframe(input logic [7:0] b);
        logic [31:0] d;
        int          lows;
        clear_rx();
        do_write(2'd2, 32'h1, 4'b0001);
        do_write(2'd0, {24'h0, b}, 4'b0001);
        do_write(2'd0, 32'($urandom), 4'b0001);
        repeat (4 * DIV + DIV / 2) @(negedge clk);
        total++; if (tx !== b[3]) begin bad++; $display("FAIL mid_bit3 got=%b want=%b", tx, b[3]); end
        #2 reset = 1'b0;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_async_tx got=%b want=1", tx); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b want=0", irq); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        do_read(2'd1, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL mid_status got=%h want=00000002", d); end
        lows = 0;
        repeat (2 * DIV) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        total++; if (lows !== 0) begin bad++; $display("FAIL mid_residual got=%0d low cycles want=0", lows); end
        total++; if (rx_q.size() !== 0) begin bad++; $display("FAIL mid_frames got=%0d want=0", rx_q.size()); end
    endtask

    initial begin
        bus.sel = 1'b0; bus.addr = 2'd0; bus.wmask = 4'b0000; bus.wdata = 32'h0; bus.rstrb = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_regs();
        test_single();
        test_back_to_back();
        test_overflow();
        test_irq();
        test_reset_midframe(8'h0F);
        test_reset_midframe(8'($urandom) & 8'hF7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
